point_fetch_buffer: RTL and testbench
=====================================

Name: point_fetch_buffer

Overview:
- Consumer end of the point-loading interface.
- Per frame it issues `next_point` request pulses to the point source (`load_points`) and captures the returned `point_scalars`/`point_color` a fixed latency later.
- Captured points are buffered in a small FIFO and presented to downstream projection/render logic as a valid/ready stream, tagged with index, tracking/virtual class and last flag.
- Credit-based request throttling guarantees the FIFO never overflows.

Parameters:
- N_TRACKING_POINTS, 4, tracking points per frame; these come first in source order.
- N_VIRTUAL_POINTS, 48, virtual points per frame; these follow the tracking points.
- FIFO_DEPTH, 8, buffer entries; power of two, at least 2.
- LOAD_LATENCY, 1, cycles from a `next_point` pulse to valid source data; at least 1.
- Derived: TOTAL = N_TRACKING_POINTS + N_VIRTUAL_POINTS; IW = $clog2(TOTAL).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- frame_start_in  input  1  single-cycle pulse; starts a frame fetch
- next_point  output  1  request pulse to the point source
- point_scalars_in  input  [2:0][15:0]  source point coordinates (x, y, z)
- point_color_in  input  4  source point color
- pt_valid_out  output  1  buffered point available
- pt_ready_in  input  1  downstream accepts the point
- pt_scalars_out  output  [2:0][15:0]  head point coordinates
- pt_color_out  output  4  head point color
- pt_index_out  output  IW  head point index within the frame, 0..TOTAL-1
- pt_tracking_out  output  1  high when pt_index_out < N_TRACKING_POINTS
- pt_last_out  output  1  high when pt_index_out == TOTAL-1
- busy_out  output  1  high when the FSM is not IDLE
- frame_done_out  output  1  one-cycle pulse at frame completion

Behaviour:
- Clocking and reset:
  - Single clock domain, `clk_in`.
  - `rst_in` is asynchronous and active-high. On assertion all state clears immediately:
    - FSM goes to IDLE.
    - Request, capture and index counters clear to 0.
    - FIFO is emptied.
    - The latency delay line is cleared, so in-flight requests are discarded.
  - All outputs read 0 during and after reset until the next frame.
  - `rst_in` is shared with the point source, so both ends restart together.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: when `frame_start_in`=1, go to FETCH and clear `req_cnt`, `cap_cnt` and `inflight`.
  - FETCH: assert `next_point` for one cycle when `req_cnt` < TOTAL and (occupancy + `inflight`) < FIFO_DEPTH. At most one request per cycle; back-to-back requests are allowed.
    - Each request increments `req_cnt` and `inflight`.
    - When the last request issues (`req_cnt` reaches TOTAL), go to DRAIN.
  - DRAIN: no requests are issued. When `cap_cnt` == TOTAL, the FIFO is empty, and the last point has been handshaken, pulse `frame_done_out` on the following cycle and return to IDLE.
  - `frame_start_in` outside IDLE is ignored and has no side effects.
- Capture:
  - `next_point` feeds a LOAD_LATENCY-deep shift register.
  - When the delayed strobe is high, sample `point_scalars_in`/`point_color_in` and push one entry tagged with index = `cap_cnt`, then increment `cap_cnt` and decrement `inflight`.
  - A push and a new request in the same cycle leave `inflight` unchanged.
- FIFO:
  - Show-ahead: `pt_valid_out` = not empty, and the head fields drive the pt_* outputs directly, all registered.
  - Pop occurs on `pt_valid_out` & `pt_ready_in`.
  - A simultaneous push and pop leaves occupancy unchanged and is legal when full.
  - Write/read pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by the credit rule. A push while full is a design error (simulation assertion).
  - Head data is held stable while `pt_valid_out`=1 and `pt_ready_in`=0.
- Latency: with `pt_ready_in`=1 throughout, a point appears on the outputs LOAD_LATENCY+1 cycles after its `next_point` pulse.
- Width rules:
  - `pt_tracking_out` and `pt_last_out` are computed at capture and stored in the FIFO.
  - Counters are IW+1 bits wide so they can hold TOTAL.
- `busy_out` = (state != IDLE).

Test Plan:
- Reset → assert `rst_in` mid-cycle with no clock edge → `next_point`, `pt_valid_out`, `busy_out` and `frame_done_out` read 0 immediately.
- Defaults, `pt_ready_in`=1, source model returns scalars {i, i+1, i+2} and color i%16 one cycle after the i-th pulse, then pulse `frame_start_in` → 52 `next_point` pulses on 52 consecutive cycles; 52 outputs with indices 0..51 and matching data; `pt_tracking_out`=1 only for indices 0..3; `pt_last_out` only at index 51; one `frame_done_out` pulse; `busy_out` falls with it.
- `pt_ready_in`=0 after start → exactly 8 pulses, then no more requests; `pt_valid_out`=1 holding index 0 data steady. Raise `pt_ready_in` → requests resume, one new pulse per pop, no loss or duplication.
- Random `pt_ready_in` (50%) with LOAD_LATENCY=3 → all 52 points arrive in order with correct data; occupancy + `inflight` never exceeds 8.
- Extra `frame_start_in` pulses during FETCH and DRAIN → no effect: request count stays 52, one `frame_done_out`.
- Reset after 20 points delivered, then a new `frame_start_in` → FIFO empty after reset; new frame delivers indices starting at 0 with all 52 points.

Source files
------------

// File: rtl/point_fetch_buffer.sv
// point_fetch_buffer: credit-throttled point fetcher feeding a show-ahead valid/ready FIFO stream
//   clk_in, rst_in                     clock, asynchronous active-high reset
//   frame_start_in                     starts a frame fetch when idle
//   next_point                         request pulse to the point source
//   point_scalars_in, point_color_in   source data, valid LOAD_LATENCY cycles after a request
//   pt_valid_out, pt_ready_in          downstream handshake
//   pt_scalars_out .. pt_last_out      head point with index / tracking / last tags
//   busy_out, frame_done_out           frame in progress, one-cycle completion pulse
module point_fetch_buffer #(
    parameter int N_TRACKING_POINTS = 4,
    parameter int N_VIRTUAL_POINTS  = 48,
    parameter int FIFO_DEPTH        = 8,
    parameter int LOAD_LATENCY      = 1,
    localparam int TOTAL = N_TRACKING_POINTS + N_VIRTUAL_POINTS,
    localparam int IW    = $clog2(TOTAL)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_start_in,
    output logic             next_point,
    input  logic [2:0][15:0] point_scalars_in,
    input  logic [3:0]       point_color_in,
    output logic             pt_valid_out,
    input  logic             pt_ready_in,
    output logic [2:0][15:0] pt_scalars_out,
    output logic [3:0]       pt_color_out,
    output logic [IW-1:0]    pt_index_out,
    output logic             pt_tracking_out,
    output logic             pt_last_out,
    output logic             busy_out,
    output logic             frame_done_out
);
    localparam int CW = IW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int SW = OW + 1;
    localparam int EW = 48 + 4 + IW + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           req_cnt, cap_cnt;
    logic [OW-1:0]           inflight, count;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [LOAD_LATENCY-1:0] dly;
    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [EW-1:0]           head;
    logic                    start, done_nxt, push, pop, credit;

    assign start        = state == IDLE && frame_start_in;
    assign push         = dly[LOAD_LATENCY-1];
    assign pop          = pt_valid_out && pt_ready_in;
    // entries already buffered plus requests still in flight must leave room for one more
    assign credit       = {1'b0, count} + {1'b0, inflight} < SW'(FIFO_DEPTH);
    assign pt_valid_out = count != '0;
    assign busy_out     = state != IDLE;
    // outputs read 0 whenever the buffer is empty, so stale entries never leak out after reset
    assign head         = pt_valid_out ? mem[rd_ptr] : '0;
    assign {pt_scalars_out, pt_color_out, pt_index_out, pt_tracking_out, pt_last_out} = head;

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt  = state;
        next_point = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE:  state_nxt = frame_start_in ? FETCH : IDLE;
            FETCH: begin
                next_point = req_cnt < CW'(TOTAL) && credit;
                state_nxt  = next_point && req_cnt == CW'(TOTAL - 1) ? DRAIN : FETCH;
            end
            DRAIN: begin
                done_nxt  = cap_cnt == CW'(TOTAL) && count == '0;
                state_nxt = done_nxt ? IDLE : DRAIN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            req_cnt        <= '0;
            cap_cnt        <= '0;
            inflight       <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            dly            <= '0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= done_nxt;
            dly            <= LOAD_LATENCY'({dly, next_point});
            if (start) begin
                req_cnt  <= '0;
                cap_cnt  <= '0;
                inflight <= '0;
            end else begin
                req_cnt  <= req_cnt + CW'(next_point);
                cap_cnt  <= cap_cnt + CW'(push);
                inflight <= inflight + OW'(next_point) - OW'(push);
            end
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + OW'(push) - OW'(pop);
        end

    always_ff @(posedge clk_in)
        if (push)
            mem[wr_ptr] <= {point_scalars_in, point_color_in, cap_cnt[IW-1:0],
                            cap_cnt < CW'(N_TRACKING_POINTS), cap_cnt == CW'(TOTAL - 1)};

    push_while_full: assert property (@(posedge clk_in) disable iff (rst_in)
        !(push && !pop && count == OW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_point_fetch_buffer.sv
// tb_point_fetch_buffer: directed and table-driven checks of point_fetch_buffer
module tb_point_fetch_buffer;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic start1 = 1'b0, ready1 = 1'b0, start3 = 1'b0, ready3 = 1'b0;
    logic np1, v1, trk1, last1, busy1, done1;
    logic np3, v3, trk3, last3, busy3, done3;
    logic [2:0][15:0] sc_in1, sc1, sc_in3, sc3;
    logic [3:0] col_in1, col1, col_in3, col3;
    logic [5:0] idx1, idx3;

    point_fetch_buffer u_dut1 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(start1), .next_point(np1),
        .point_scalars_in(sc_in1), .point_color_in(col_in1), .pt_valid_out(v1),
        .pt_ready_in(ready1), .pt_scalars_out(sc1), .pt_color_out(col1),
        .pt_index_out(idx1), .pt_tracking_out(trk1), .pt_last_out(last1),
        .busy_out(busy1), .frame_done_out(done1));

    point_fetch_buffer #(.LOAD_LATENCY(3)) u_dut3 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(start3), .next_point(np3),
        .point_scalars_in(sc_in3), .point_color_in(col_in3), .pt_valid_out(v3),
        .pt_ready_in(ready3), .pt_scalars_out(sc3), .pt_color_out(col3),
        .pt_index_out(idx3), .pt_tracking_out(trk3), .pt_last_out(last3),
        .busy_out(busy3), .frame_done_out(done3));

    function automatic logic [2:0][15:0] mk(input int i);
        return {16'(i + 2), 16'(i + 1), 16'(i)};
    endfunction

    function automatic logic [59:0] exp_pt(input int k);
        return {mk(k), 4'(k), 6'(k), k < 4, k == 51};
    endfunction

    // source with latency 1: data registered on the edge that samples the request
    int src1;
    always @(posedge clk or posedge rst)
        if (rst) begin
            src1 <= 0;
            sc_in1 <= '0;
            col_in1 <= '0;
        end else if (start1 && !busy1) src1 <= 0;
        else if (np1) begin
            sc_in1 <= mk(src1);
            col_in1 <= 4'(src1);
            src1 <= src1 + 1;
        end

    // source with latency 3: request index travels down a 3-stage pipe
    int src3;
    int p3 [3];
    always @(posedge clk or posedge rst)
        if (rst) begin
            src3 <= 0;
            p3[0] <= 0; p3[1] <= 0; p3[2] <= 0;
        end else begin
            p3[0] <= src3; p3[1] <= p3[0]; p3[2] <= p3[1];
            if (start3 && !busy3) src3 <= 0;
            else if (np3) src3 <= src3 + 1;
        end
    assign sc_in3  = mk(p3[2]);
    assign col_in3 = 4'(p3[2]);

    int cyc = 0, np1_n = 0, rx1_n = 0, done1_n = 0, np3_n = 0, rx3_n = 0, done3_n = 0;
    int np1_cyc [512];
    int rx1_cyc [512];
    logic [59:0] rx1 [512];
    logic [59:0] rx3 [512];
    logic done_busy = 1'b1, done_prev_busy = 1'b0, prev_busy1 = 1'b0;
    int max_out3 = 0, out3;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (np1) begin
                if (np1_n < 512) np1_cyc[np1_n] = cyc;
                np1_n++;
            end
            if (v1 && ready1 && rx1_n < 512) begin
                rx1[rx1_n] = {sc1, col1, idx1, trk1, last1};
                rx1_cyc[rx1_n] = cyc;
                rx1_n++;
            end
            if (done1) begin
                done1_n++;
                done_busy = busy1;
                done_prev_busy = prev_busy1;
            end
            prev_busy1 = busy1;
            out3 = np3_n - rx3_n;
            if (out3 > max_out3) max_out3 = out3;
            if (np3) np3_n++;
            if (v3 && ready3 && rx3_n < 512) begin
                rx3[rx3_n] = {sc3, col3, idx3, trk3, last3};
                rx3_n++;
            end
            if (done3) done3_n++;
        end
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int base);
        for (int k = 0; k < 1000 && done1_n == base; k++) tick();
        chk("done_timeout", 64'(done1_n > base), 64'd1);
        repeat (10) tick();
    endtask

    task automatic chk_frame1(input string tag, input int base_rx);
        for (int k = 0; k < 52; k++)
            chk({tag, "_point"}, rx1[base_rx + k], exp_pt(k));
    endtask

    typedef struct {
        int         idx;
        logic       trk;
        logic       last;
        logic [3:0] col;
        logic [15:0] z;
    } vec_t;

    vec_t tv [6];
    int b_np, b_rx, b_done, hold_bad;
    logic [59:0] held;
    logic have;

    initial begin
        tv[0] = '{0,  1'b1, 1'b0, 4'h0, 16'd2};
        tv[1] = '{3,  1'b1, 1'b0, 4'h3, 16'd5};
        tv[2] = '{4,  1'b0, 1'b0, 4'h4, 16'd6};
        tv[3] = '{16, 1'b0, 1'b0, 4'h0, 16'd18};
        tv[4] = '{50, 1'b0, 1'b0, 4'h2, 16'd52};
        tv[5] = '{51, 1'b0, 1'b1, 4'h3, 16'd53};

        // asynchronous reset mid-cycle, no clock edge yet
        #3 rst = 1'b1;
        #1;
        chk("rst_np", 64'(np1), 64'd0);
        chk("rst_valid", 64'(v1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_scalars", 64'(sc1), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // frame A: full throughput
        ready1 = 1'b1;
        b_np = np1_n; b_rx = rx1_n; b_done = done1_n;
        pulse1();
        wait_done1(b_done);
        chk("a_pulses", 64'(np1_n - b_np), 64'd52);
        chk("a_consecutive", 64'(np1_cyc[b_np + 51] - np1_cyc[b_np]), 64'd51);
        chk("a_latency", 64'(rx1_cyc[b_rx] - np1_cyc[b_np]), 64'd2);
        chk("a_points", 64'(rx1_n - b_rx), 64'd52);
        chk("a_done_cnt", 64'(done1_n - b_done), 64'd1);
        chk("a_busy_at_done", 64'(done_busy), 64'd0);
        chk("a_busy_before_done", 64'(done_prev_busy), 64'd1);
        chk_frame1("a", b_rx);
        foreach (tv[i])
            chk("a_table", {rx1[b_rx + tv[i].idx][59:44], rx1[b_rx + tv[i].idx][11:8],
                            rx1[b_rx + tv[i].idx][7:2], rx1[b_rx + tv[i].idx][1:0]},
                           {tv[i].z, tv[i].col, 6'(tv[i].idx), tv[i].trk, tv[i].last});

        // frame B: stalled downstream, extra starts during FETCH and DRAIN
        ready1 = 1'b0;
        b_np = np1_n; b_rx = rx1_n; b_done = done1_n;
        pulse1();
        hold_bad = 0; have = 1'b0; held = '0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (v1) begin
                if (!have) begin
                    held = {sc1, col1, idx1, trk1, last1};
                    have = 1'b1;
                end else if ({sc1, col1, idx1, trk1, last1} != held) hold_bad++;
            end
        end
        chk("b_stall_pulses", 64'(np1_n - b_np), 64'd8);
        chk("b_stall_valid", 64'(v1), 64'd1);
        chk("b_stall_index", 64'(idx1), 64'd0);
        chk("b_stall_scalars", 64'(sc1), {16'd0, 16'd2, 16'd1, 16'd0});
        chk("b_hold_stable", 64'(hold_bad), 64'd0);
        pulse1();
        repeat (5) tick();
        chk("b_fetch_start_ignored", 64'(np1_n - b_np), 64'd8);
        ready1 = 1'b1;
        for (int k = 0; k < 500 && np1_n - b_np < 52; k++) tick();
        chk("b_drain_busy", 64'(busy1), 64'd1);
        pulse1();
        wait_done1(b_done);
        chk("b_pulses", 64'(np1_n - b_np), 64'd52);
        chk("b_points", 64'(rx1_n - b_rx), 64'd52);
        chk("b_done_cnt", 64'(done1_n - b_done), 64'd1);
        chk("b_idle", 64'(busy1), 64'd0);
        chk_frame1("b", b_rx);

        // reset after 20 points delivered, then a fresh frame
        b_rx = rx1_n;
        pulse1();
        for (int k = 0; k < 500 && rx1_n - b_rx < 20; k++) tick();
        rst = 1'b1;
        #1;
        chk("r_valid", 64'(v1), 64'd0);
        chk("r_busy", 64'(busy1), 64'd0);
        chk("r_np", 64'(np1), 64'd0);
        chk("r_index", 64'(idx1), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("r_valid_after", 64'(v1), 64'd0);
        b_np = np1_n; b_rx = rx1_n; b_done = done1_n;
        pulse1();
        wait_done1(b_done);
        chk("r_pulses", 64'(np1_n - b_np), 64'd52);
        chk("r_points", 64'(rx1_n - b_rx), 64'd52);
        chk_frame1("r", b_rx);

        // latency 3 with random backpressure
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 5000 && done3_n == 0; k++) begin
            ready3 = 1'($urandom_range(0, 1));
            tick();
        end
        ready3 = 1'b0;
        repeat (5) tick();
        chk("l3_done", 64'(done3_n), 64'd1);
        chk("l3_pulses", 64'(np3_n), 64'd52);
        chk("l3_points", 64'(rx3_n), 64'd52);
        chk("l3_credit", 64'(max_out3 <= 8), 64'd1);
        for (int k = 0; k < 52; k++) chk("l3_point", rx3[k], exp_pt(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
